pc_sequencer: RTL and testbench

Fetch-side controller that sequences the program counter and the instruction-memory request. It consumes the branch unit's PC-mux select and targets, and decides when a redirect may be applied without breaking an outstanding fetch handshake. It also drives the pipeline flush window after a redirect. It sits between the branch unit / hazard logic and the IF stage, and owns the architectural fetch PC.

---
 rtl/riscv_cpu_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// Shared CPU definitions: branch-unit PC-mux selects plus the fetch
// sequencer's state type and PC increment.
package riscv_cpu_pkg;

    localparam int BU_MUX_WIDTH = 2;

    localparam logic [BU_MUX_WIDTH-1:0] BU_PC_NEXT   = 2'd0;
    localparam logic [BU_MUX_WIDTH-1:0] BU_PC_BRANCH = 2'd1;
    localparam logic [BU_MUX_WIDTH-1:0] BU_PC_JAL    = 2'd2;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        REDIR_WAIT,
        FLUSH
    } pc_seq_state_e;

    // Fetch addresses are always word aligned; low target bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Branch-unit inputs and instruction-fetch handshake of the PC sequencer.
interface pc_sequencer_if;
    import riscv_cpu_pkg::*;

    logic [BU_MUX_WIDTH-1:0] bu_pc_mux_i;
    logic [31:0]             branch_target_i;
    logic [31:0]             jal_target_i;
    logic                    stall_i;
    logic                    imem_gnt_i;
    logic                    imem_req_o;
    logic [31:0]             pc_o;
    logic                    flush_o;
    logic                    busy_o;

    modport slave (
        input  bu_pc_mux_i, branch_target_i, jal_target_i, stall_i, imem_gnt_i,
        output imem_req_o, pc_o, flush_o, busy_o
    );

    modport master (
        output bu_pc_mux_i, branch_target_i, jal_target_i, stall_i, imem_gnt_i,
        input  imem_req_o, pc_o, flush_o, busy_o
    );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequences instruction-memory requests and applies branch
// redirects only when no fetch handshake would be broken.
module pc_sequencer
    import riscv_cpu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR    = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    pc_sequencer_if.slave   bus
);

    localparam int              CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pc_seq_state_e    state_q;
    logic [31:0]      pc_q;
    logic [31:0]      redir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_outstanding_q;

    logic             redir;
    logic             pending;
    logic             imem_req;
    logic [31:0]      target;

    assign redir  = (bus.bu_pc_mux_i != BU_PC_NEXT);
    assign target = align_word((bus.bu_pc_mux_i == BU_PC_BRANCH) ? bus.branch_target_i
                                                                 : bus.jal_target_i);

    // Once raised, a request holds until granted, so stall only gates new ones.
    always_comb begin
        imem_req = 1'b0;
        case (state_q)
            FETCH:      imem_req = req_outstanding_q | ~bus.stall_i;
            REDIR_WAIT: imem_req = 1'b1;
            default:    imem_req = 1'b0;
        endcase
    end

    assign pending        = imem_req & ~bus.imem_gnt_i;
    assign bus.imem_req_o = imem_req;
    assign bus.pc_o       = pc_q;
    assign bus.flush_o    = (state_q == FLUSH);
    assign bus.busy_o     = (state_q != FETCH);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q           <= BOOT;
            pc_q              <= BOOT_ADDR;
            redir_q           <= 32'h0;
            cnt_q             <= '0;
            req_outstanding_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (redir && !pending) begin
                        pc_q              <= target;
                        cnt_q             <= CNT_LOAD;
                        req_outstanding_q <= 1'b0;
                        state_q           <= FLUSH;
                    end else if (redir) begin
                        // Park the redirect until the in-flight fetch is accepted.
                        redir_q           <= target;
                        req_outstanding_q <= 1'b1;
                        state_q           <= REDIR_WAIT;
                    end else begin
                        if (imem_req && bus.imem_gnt_i) begin
                            pc_q <= pc_q + PC_INCR;
                        end
                        req_outstanding_q <= pending;
                    end
                end
                REDIR_WAIT: begin
                    if (bus.imem_gnt_i) begin
                        pc_q              <= redir_q;
                        cnt_q             <= CNT_LOAD;
                        req_outstanding_q <= 1'b0;
                        state_q           <= FLUSH;
                    end
                end
                FLUSH: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pc_sequencer;

    localparam logic [31:0] BOOT_ADDR    = 32'h8000_0000;
    localparam int          FLUSH_CYCLES = 2;

    localparam logic [1:0] SEL_NEXT   = riscv_cpu_pkg::BU_PC_NEXT;
    localparam logic [1:0] SEL_BRANCH = riscv_cpu_pkg::BU_PC_BRANCH;
    localparam logic [1:0] SEL_JAL    = riscv_cpu_pkg::BU_PC_JAL;

    logic clk;
    logic rstN;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .BOOT_ADDR    (BOOT_ADDR),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the fetch side should look like this cycle.
    logic        mValid     = 1'b0;
    logic        mBooting   = 1'b0;
    logic [31:0] mPc        = 32'h0;
    int          mFlushLeft = 0;
    logic        mHeld      = 1'b0;
    logic        mWaiting   = 1'b0;
    logic [31:0] mWaitPc    = 32'h0;

    function automatic logic [31:0] modelTarget();
        logic [31:0] t;
        t = (bus.bu_pc_mux_i == SEL_BRANCH) ? bus.branch_target_i : bus.jal_target_i;
        return {t[31:2], 2'b00};
    endfunction

    function automatic logic modelReq();
        if (mBooting || mFlushLeft > 0) return 1'b0;
        if (mWaiting) return 1'b1;
        return mHeld || !bus.stall_i;
    endfunction

    always @(posedge clk) begin
        logic req;
        logic stuck;
        logic wantRedir;
        if (!rstN) begin
            mValid     = 1'b1;
            mBooting   = 1'b1;
            mPc        = BOOT_ADDR;
            mFlushLeft = 0;
            mHeld      = 1'b0;
            mWaiting   = 1'b0;
        end else if (mValid) begin
            req       = modelReq();
            stuck     = req && !bus.imem_gnt_i;
            wantRedir = (bus.bu_pc_mux_i != SEL_NEXT);
            if (mBooting) begin
                mBooting = 1'b0;
            end else if (mFlushLeft > 0) begin
                mFlushLeft = mFlushLeft - 1;
            end else if (mWaiting) begin
                if (bus.imem_gnt_i) begin
                    mPc        = mWaitPc;
                    mFlushLeft = FLUSH_CYCLES;
                    mWaiting   = 1'b0;
                    mHeld      = 1'b0;
                end
            end else if (wantRedir && !stuck) begin
                mPc        = modelTarget();
                mFlushLeft = FLUSH_CYCLES;
                mHeld      = 1'b0;
            end else if (wantRedir) begin
                mWaiting = 1'b1;
                mWaitPc  = modelTarget();
            end else begin
                if (req && bus.imem_gnt_i) mPc = mPc + 32'd4;
                mHeld = stuck;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("model_pc",    bus.pc_o,              mPc);
            checkOutput("model_req",   {31'b0, bus.imem_req_o}, {31'b0, modelReq()});
            checkOutput("model_flush", {31'b0, bus.flush_o},  {31'b0, (mFlushLeft > 0)});
            checkOutput("model_busy",  {31'b0, bus.busy_o},
                        {31'b0, (mBooting || mWaiting || mFlushLeft > 0)});
        end
    end

    // Inputs change just after a rising edge; returns at the following falling edge.
    task automatic applyStimulus(input logic rst, input logic [1:0] sel,
                                 input logic [31:0] br, input logic [31:0] jal,
                                 input logic stall, input logic gnt);
        @(posedge clk);
        #1;
        rstN                = rst;
        bus.bu_pc_mux_i     = sel;
        bus.branch_target_i = br;
        bus.jal_target_i    = jal;
        bus.stall_i         = stall;
        bus.imem_gnt_i      = gnt;
        @(negedge clk);
    endtask

    task automatic expectState(input string name, input logic [31:0] pc,
                               input logic req, input logic flush);
        checkOutput({name, "_pc"},    bus.pc_o,               pc);
        checkOutput({name, "_req"},   {31'b0, bus.imem_req_o}, {31'b0, req});
        checkOutput({name, "_flush"}, {31'b0, bus.flush_o},   {31'b0, flush});
    endtask

    initial begin
        rstN                = 1'b0;
        bus.bu_pc_mux_i     = SEL_NEXT;
        bus.branch_target_i = 32'h0;
        bus.jal_target_i    = 32'h0;
        bus.stall_i         = 1'b0;
        bus.imem_gnt_i      = 1'b0;

        // Reset held two cycles, then released
        applyStimulus(0, SEL_NEXT, 0, 0, 0, 0);
        applyStimulus(0, SEL_NEXT, 0, 0, 0, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("boot", 32'h8000_0000, 0, 0);
        checkOutput("boot_busy", {31'b0, bus.busy_o}, 32'd1);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("first_req", 32'h8000_0000, 1, 0);

        // Streaming fetch, then branch taken on the granted cycle
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 1);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 1);
        expectState("stream4", 32'h8000_0004, 1, 0);
        applyStimulus(1, SEL_BRANCH, 32'h8000_0100, 0, 0, 1);
        expectState("stream8", 32'h8000_0008, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("br_flush1", 32'h8000_0100, 0, 1);
        applyStimulus(1, SEL_BRANCH, 32'h1234_5678, 0, 0, 1);
        expectState("br_flush2", 32'h8000_0100, 0, 1);

        // Jump to 0x8000_0010, then JAL while that fetch is still pending
        applyStimulus(1, SEL_JAL, 0, 32'h8000_0010, 0, 1);
        expectState("br_refetch", 32'h8000_0100, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        applyStimulus(1, SEL_JAL, 0, 32'h8000_0203, 0, 0);
        expectState("pend_req", 32'h8000_0010, 1, 0);
        applyStimulus(1, SEL_BRANCH, 32'h8000_0500, 0, 1, 0);
        expectState("wait1", 32'h8000_0010, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 1);
        expectState("wait_gnt", 32'h8000_0010, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("jal_flush1", 32'h8000_0200, 0, 1);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("jal_flush2", 32'h8000_0200, 0, 1);

        // Wrap: jump to the last word, then step past it
        applyStimulus(1, SEL_JAL, 0, 32'hFFFF_FFFC, 0, 1);
        expectState("jal_refetch", 32'h8000_0200, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 1);
        expectState("top_word", 32'hFFFF_FFFC, 1, 0);

        // Stall with no request, then stall rising while a request is pending
        applyStimulus(1, SEL_NEXT, 0, 0, 1, 0);
        expectState("wrapped_stall", 32'h0000_0000, 0, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("req_unstalled", 32'h0000_0000, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 1, 0);
        expectState("req_held", 32'h0000_0000, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 1, 1);
        applyStimulus(1, SEL_NEXT, 0, 0, 1, 0);
        expectState("req_dropped", 32'h0000_0004, 0, 0);

        // Stall and redirect together with nothing pending: redirect wins
        applyStimulus(1, SEL_BRANCH, 32'h8000_0041, 0, 1, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("stall_br", 32'h8000_0040, 0, 1);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);

        // Reset while a redirect is parked; it must never take effect
        applyStimulus(1, SEL_JAL, 0, 32'h8000_0300, 0, 0);
        expectState("park_req", 32'h8000_0040, 1, 0);
        applyStimulus(0, SEL_NEXT, 0, 0, 0, 1);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 1);
        expectState("mid_reset", 32'h8000_0000, 0, 0);
        checkOutput("mid_reset_busy", {31'b0, bus.busy_o}, 32'd1);
        applyStimulus(1, SEL_BRANCH, 32'h8000_0500, 0, 0, 1);
        expectState("after_reset", 32'h8000_0000, 1, 0);
        applyStimulus(1, SEL_JAL, 0, 32'h8000_0999, 0, 1);
        expectState("late_flush1", 32'h8000_0500, 0, 1);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("late_fetch", 32'h8000_0500, 1, 0);
        checkOutput("late_busy", {31'b0, bus.busy_o}, 32'd0);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 1);
        applyStimulus(1, SEL_NEXT, 0, 0, 0, 0);
        expectState("late_step", 32'h8000_0504, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
